// File: rtl/nes_joypad_port.sv
// NES $4016 joypad port: PS/2 gamepad byte in, CPU strobe/shift serial bit out.
// Optional JOYPAD_TURBO_EN gates A/B with a free-running turbo phase.
module nes_joypad_port #(
    parameter int unsigned TURBO_HALF_PERIOD = 1000000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] keys_data_i,
    input  logic       keys_valid_i,
    output logic       keys_ready_o,
    input  logic       strobe_we_i,
    input  logic       strobe_d_i,
    input  logic       rd_i,
    output logic       serial_o,
    output logic [3:0] read_count_o
);

    localparam int unsigned KEY_W = 8;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] ST_STROBE = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(8);

    if (TURBO_HALF_PERIOD == 0) begin : g_bad_period
        $error("TURBO_HALF_PERIOD must be at least 1");
    end

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [KEY_W-1:0] keys_r;
    logic [KEY_W-1:0] sr;
    logic [KEY_W-1:0] sr_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [KEY_W-1:0] snapshot;

`ifdef JOYPAD_TURBO_EN
    localparam int unsigned TW = (TURBO_HALF_PERIOD > 1) ? $clog2(TURBO_HALF_PERIOD) : 1;

    logic [TW-1:0] turbo_cnt;
    logic          turbo_phase;

    // Free-running half-period counter; phase flips on wrap.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else if (turbo_cnt == TW'(TURBO_HALF_PERIOD - 1)) begin
            turbo_cnt   <= '0;
            turbo_phase <= ~turbo_phase;
        end else begin
            turbo_cnt <= turbo_cnt + TW'(1);
        end
    end

    assign snapshot = {keys_r[7:2], keys_r[1:0] & {2{turbo_phase}}};
`else
    assign snapshot = keys_r;
`endif

    // Key byte holding register; the receiver is always allowed to overwrite it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            keys_r       <= '0;
            keys_ready_o <= 1'b0;
        end else begin
            keys_ready_o <= 1'b1;
            if (keys_valid_i && keys_ready_o) begin
                keys_r <= keys_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_DONE;
            sr           <= '1;
            read_count_o <= CNT_FULL;
        end else begin
            state        <= state_nxt;
            sr           <= sr_nxt;
            read_count_o <= cnt_nxt;
        end
    end

    // A strobe write always wins over a read in the same cycle.
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = read_count_o;

        if (state == ST_STROBE) begin
            sr_nxt = snapshot;
        end

        if (strobe_we_i) begin
            if (strobe_d_i) begin
                state_nxt = ST_STROBE;
            end else if (state == ST_STROBE) begin
                state_nxt = ST_SHIFT;
                cnt_nxt   = '0;
            end
        end else if (rd_i && (state != ST_STROBE)) begin
            sr_nxt = {1'b1, sr[KEY_W-1:1]};
            if (read_count_o != CNT_FULL) begin
                cnt_nxt = read_count_o + CNT_W'(1);
            end
            if ((state == ST_SHIFT) && (read_count_o >= CNT_W'(7))) begin
                state_nxt = ST_DONE;
            end
        end

        if ((state != ST_STROBE) && (state != ST_SHIFT) && (state != ST_DONE)) begin
            state_nxt = ST_DONE;
        end
    end

    assign serial_o = (state == ST_STROBE) ? snapshot[0] : sr[0];

endmodule
